// File: rtl/serial_adder_if.sv
// serial_adder_if: handshake and operand/result bundle for serial_adder.
//   master modport (requester): drives start, first, second, cin (and sub when
//                               SERIAL_ADDER_SUB_EN is defined); observes busy, done, sum, cout.
//   slave modport (adder):      the mirror image.
// Macro SERIAL_ADDER_SUB_EN adds the 1-bit sub request alongside the operands.
interface serial_adder_if #(
    parameter int unsigned WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] first;
    logic [WIDTH-1:0] second;
    logic             cin;
`ifdef SERIAL_ADDER_SUB_EN
    logic             sub;
`endif
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;

`ifdef SERIAL_ADDER_SUB_EN
    modport master (output start, first, second, cin, sub, input busy, done, sum, cout);
    modport slave  (input start, first, second, cin, sub, output busy, done, sum, cout);
`else
    modport master (output start, first, second, cin, input busy, done, sum, cout);
    modport slave  (input start, first, second, cin, output busy, done, sum, cout);
`endif
endinterface

// File: rtl/serial_adder.sv
// serial_adder: multi-cycle WIDTH-bit adder that consumes STEP bits per clock through a
// registered carry. {cout, sum} = first + second + cin, available NSTEP edges after the
// accepted start, held until the next operation completes.
// Ports:
//   clk   - rising-edge clock
//   rst_n - asynchronous active-low reset; aborts any operation in flight
//   bus   - serial_adder_if slave: start/first/second/cin in, busy/done/sum/cout out
// Optional macro SERIAL_ADDER_SUB_EN: adds bus.sub; sub=1 computes first - second
// (B inverted, carry-in forced to 1, cin ignored), cout=1 meaning no borrow.
module serial_adder #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned STEP  = 1
) (
    input  logic           clk,
    input  logic           rst_n,
    serial_adder_if.slave  bus
);
    localparam int unsigned NSTEP = WIDTH / STEP;
    localparam int unsigned CNT_W = (NSTEP > 1) ? $clog2(NSTEP) : 1;
    localparam int unsigned SUM_W = STEP + 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NSTEP - 1);

    if (WIDTH < 1 || STEP < 1 || (WIDTH % STEP) != 0) begin : g_bad_param
        $error("serial_adder: STEP must be >= 1 and divide WIDTH exactly");
    end

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e           r_state;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic             r_carry;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_res;
    logic [WIDTH-1:0] r_sum;
    logic             r_cout;
    logic             r_busy;
    logic             r_done;

    logic [STEP:0]    w_step;
    logic [WIDTH-1:0] w_res_next;
    logic [WIDTH-1:0] w_b_load;
    logic             w_c_load;

`ifdef SERIAL_ADDER_SUB_EN
    // Subtraction as A + ~B + 1.
    assign w_b_load = bus.sub ? ~bus.second : bus.second;
    assign w_c_load = bus.sub ? 1'b1 : bus.cin;
`else
    assign w_b_load = bus.second;
    assign w_c_load = bus.cin;
`endif

    // One STEP-wide slice of the addition; top bit is the carry into the next slice.
    assign w_step = {1'b0, r_a[STEP-1:0]} + {1'b0, r_b[STEP-1:0]} + SUM_W'(r_carry);

    // Result bits enter at the MSB end so the LSB slice ends up at bit 0 after NSTEP shifts.
    if (STEP == WIDTH) begin : g_res_single
        assign w_res_next = w_step[STEP-1:0];
    end else begin : g_res_shift
        assign w_res_next = {w_step[STEP-1:0], r_res[WIDTH-1:STEP]};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= StIdle;
            r_a     <= '0;
            r_b     <= '0;
            r_carry <= 1'b0;
            r_cnt   <= '0;
            r_res   <= '0;
            r_sum   <= '0;
            r_cout  <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            case (r_state)
                StIdle: begin
                    if (bus.start) begin
                        r_a     <= bus.first;
                        r_b     <= w_b_load;
                        r_carry <= w_c_load;
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                        r_state <= StRun;
                    end
                end
                StRun: begin
                    r_a     <= r_a >> STEP;
                    r_b     <= r_b >> STEP;
                    r_res   <= w_res_next;
                    r_carry <= w_step[STEP];
                    r_cnt   <= r_cnt + CNT_W'(1);
                    if (r_cnt == LAST_CNT) begin
                        r_sum   <= w_res_next;
                        r_cout  <= w_step[STEP];
                        r_done  <= 1'b1;
                        r_state <= StDone;
                    end
                end
                StDone: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= StIdle;
                end
                default: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= StIdle;
                end
            endcase
        end
    end

    assign bus.busy = r_busy;
    assign bus.done = r_done;
    assign bus.sum  = r_sum;
    assign bus.cout = r_cout;
endmodule
